// File: rtl/serial_alu32_if.sv
// Operand/result bundle between a requester and the bit-serial ALU sequencer.
interface serial_alu32_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [2:0]       control;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] out;
   logic             overflow;
   logic             zero;
   logic             negative;

   modport master (
      output start, A, B, control,
      input  busy, done, out, overflow, zero, negative
   );

   modport slave (
      input  start, A, B, control,
      output busy, done, out, overflow, zero, negative
   );
endinterface

// File: rtl/serial_alu32.sv
// Bit-serial ALU sequencer: one 1-bit slice per cycle, LSB first, registered ripple carry.
// Optional SERIAL_ALU_FLAGS_EN enables the overflow/zero/negative flags (tied to 0 otherwise).
module serial_alu32 #(
   parameter int WIDTH = 32
) (
   input  logic          clock,
   input  logic          reset,
   serial_alu32_if.slave bus
);
   localparam int CNT_W = $clog2(WIDTH);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_r;
   state_t           state_s;
   logic             accept_s;
   logic             finish_s;

   logic [WIDTH-1:0] a_sh_r;
   logic [WIDTH-1:0] b_sh_r;
   logic [WIDTH-1:0] res_sh_r;
   logic [2:0]       ctrl_r;
   logic             carry_r;
   logic [CNT_W-1:0] cnt_r;

   logic             b_eff_s;
   logic             sum_s;
   logic             cout_s;
   logic             logic_s;
   logic             res_bit_s;
   logic             last_bit_s;
   logic [WIDTH-1:0] result_s;

   logic             busy_r;
   logic             done_r;
   logic [WIDTH-1:0] out_r;

   assign last_bit_s = (cnt_r == CNT_W'(WIDTH - 1));
   assign result_s   = {res_bit_s, res_sh_r[WIDTH-1:1]};

   // One-bit ALU slice; B is inverted for the subtract codes through control[0].
   always_comb begin
      b_eff_s = b_sh_r[0] ^ ctrl_r[0];
      sum_s   = a_sh_r[0] ^ b_eff_s ^ carry_r;
      cout_s  = (a_sh_r[0] & b_eff_s) | (carry_r & (a_sh_r[0] ^ b_eff_s));
      logic_s = 1'b0;
      case (ctrl_r[1:0])
         2'b00:   logic_s = a_sh_r[0] & b_sh_r[0];
         2'b01:   logic_s = a_sh_r[0] | b_sh_r[0];
         2'b10:   logic_s = ~(a_sh_r[0] | b_sh_r[0]);
         2'b11:   logic_s = a_sh_r[0] ^ b_sh_r[0];
         default: logic_s = 1'b0;
      endcase
      if (ctrl_r[2]) begin
         res_bit_s = logic_s;
      end else begin
         res_bit_s = sum_s;
      end
   end

   // FSM state register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // FSM next-state and acceptance/completion strobes.
   always_comb begin
      state_s  = state_r;
      accept_s = 1'b0;
      finish_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (bus.start) begin
               state_s  = ST_RUN;
               accept_s = 1'b1;
            end else begin
               state_s  = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (last_bit_s) begin
               state_s  = ST_DONE;
               finish_s = 1'b1;
            end else begin
               state_s  = ST_RUN;
            end
         end
         ST_DONE: state_s = ST_IDLE;
         default: state_s = ST_IDLE;
      endcase
   end

   // Operand shift registers, carry chain and bit counter.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         a_sh_r   <= {WIDTH{1'b0}};
         b_sh_r   <= {WIDTH{1'b0}};
         res_sh_r <= {WIDTH{1'b0}};
         ctrl_r   <= 3'd0;
         carry_r  <= 1'b0;
         cnt_r    <= {CNT_W{1'b0}};
      end else if (accept_s) begin
         a_sh_r   <= bus.A;
         b_sh_r   <= bus.B;
         res_sh_r <= {WIDTH{1'b0}};
         ctrl_r   <= bus.control;
         carry_r  <= bus.control[0];
         cnt_r    <= {CNT_W{1'b0}};
      end else if (state_r == ST_RUN) begin
         a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
         b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
         res_sh_r <= result_s;
         carry_r  <= cout_s;
         cnt_r    <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         a_sh_r   <= a_sh_r;
         b_sh_r   <= b_sh_r;
         res_sh_r <= res_sh_r;
         carry_r  <= carry_r;
         cnt_r    <= cnt_r;
      end
   end

   // Status and result registers; the result is written on the edge entering DONE.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         busy_r <= 1'b0;
         done_r <= 1'b0;
         out_r  <= {WIDTH{1'b0}};
      end else begin
         busy_r <= (state_s != ST_IDLE);
         done_r <= finish_s;
         if (finish_s) begin
            out_r <= result_s;
         end else begin
            out_r <= out_r;
         end
      end
   end

   assign bus.busy = busy_r;
   assign bus.done = done_r;
   assign bus.out  = out_r;

`ifdef SERIAL_ALU_FLAGS_EN
   logic ovf_s;
   logic overflow_r;
   logic zero_r;
   logic negative_r;

   // At the last bit, carry_r is the carry into the MSB and cout_s the carry out of it.
   always_comb begin
      ovf_s = 1'b0;
      case (ctrl_r)
         3'd0:    ovf_s = cout_s;
         3'd2:    ovf_s = carry_r ^ cout_s;
         3'd3:    ovf_s = carry_r ^ cout_s;
         default: ovf_s = 1'b0;
      endcase
   end

   // Flag registers, written together with the result.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         overflow_r <= 1'b0;
         zero_r     <= 1'b1;
         negative_r <= 1'b0;
      end else if (finish_s) begin
         overflow_r <= ovf_s;
         zero_r     <= (result_s == {WIDTH{1'b0}});
         negative_r <= result_s[WIDTH-1];
      end else begin
         overflow_r <= overflow_r;
         zero_r     <= zero_r;
         negative_r <= negative_r;
      end
   end

   assign bus.overflow = overflow_r;
   assign bus.zero     = zero_r;
   assign bus.negative = negative_r;
`else
   assign bus.overflow = 1'b0;
   assign bus.zero     = 1'b0;
   assign bus.negative = 1'b0;
`endif
endmodule

// File: tb/tb_serial_alu32.sv
// Self-checking bench for serial_alu32: directed cases plus random ops against an arithmetic model.
module tb_serial_alu32;
   localparam int W = 32;
`ifdef SERIAL_ALU_FLAGS_EN
   localparam bit FLAGS_EN = 1'b1;
`else
   localparam bit FLAGS_EN = 1'b0;
`endif

   logic clock;
   logic reset;
   int   n_asserts;
   int   n_fail;
   logic [W-1:0] prev_out;

   serial_alu32_if #(.WIDTH(W)) bus ();

   serial_alu32 #(.WIDTH(W)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: whole-word arithmetic; returns {overflow, result}.
   function automatic logic [W:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [2:0] ctrl);
      logic [W:0]   wide;
      logic [W-1:0] res;
      logic         ovf;
      ovf = 1'b0;
      res = '0;
      case (ctrl)
         3'd0: begin
            wide = {1'b0, a} + {1'b0, b};
            res  = wide[W-1:0];
            ovf  = wide[W];
         end
         3'd1: res = a - b;
         3'd2: begin
            res = a + b;
            ovf = (a[W-1] == b[W-1]) && (res[W-1] != a[W-1]);
         end
         3'd3: begin
            res = a - b;
            ovf = (a[W-1] != b[W-1]) && (res[W-1] != a[W-1]);
         end
         3'd4: res = a & b;
         3'd5: res = a | b;
         3'd6: res = ~(a | b);
         default: res = a ^ b;
      endcase
      return {ovf, res};
   endfunction

   // Caller is at a negedge with the DUT idle; start is sampled on the next posedge.
   task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2:0] ctrl, input bit inject);
      logic [W:0] exp;
      int         cyc;
      exp = ref_op(a, b, ctrl);
      bus.A       = a;
      bus.B       = b;
      bus.control = ctrl;
      bus.start   = 1'b1;
      @(posedge clock);
      @(negedge clock);
      bus.start = 1'b0;
      check({tag, ".busy_rise"}, bus.busy, 1'b1);
      cyc = 0;
      while (!bus.done && cyc < W + 8) begin
         @(posedge clock);
         cyc++;
         @(negedge clock);
         if (inject && (cyc == 5 || cyc == 10)) begin
            bus.A       = $urandom;
            bus.B       = $urandom;
            bus.control = 3'($urandom_range(0, 7));
            bus.start   = 1'b1;
         end else begin
            bus.start   = 1'b0;
         end
         if (cyc == W / 2) begin
            check({tag, ".out_hold"}, bus.out, prev_out);
         end
      end
      bus.start = 1'b0;
      check({tag, ".done"}, bus.done, 1'b1);
      check({tag, ".latency"}, cyc, W);
      check({tag, ".out"}, bus.out, exp[W-1:0]);
      check({tag, ".overflow"}, bus.overflow, FLAGS_EN & exp[W]);
      check({tag, ".zero"}, bus.zero, FLAGS_EN & (exp[W-1:0] == '0));
      check({tag, ".negative"}, bus.negative, FLAGS_EN & exp[W-1]);
      prev_out = exp[W-1:0];
      @(posedge clock);
      @(negedge clock);
      check({tag, ".done_pulse"}, bus.done, 1'b0);
      check({tag, ".busy_fall"}, bus.busy, 1'b0);
      check({tag, ".out_after"}, bus.out, prev_out);
   endtask

   initial begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic [2:0]   rc;
      n_asserts   = 0;
      n_fail      = 0;
      prev_out    = '0;
      reset       = 1'b0;
      bus.start   = 1'b0;
      bus.A       = '0;
      bus.B       = '0;
      bus.control = 3'd0;
      repeat (3) @(negedge clock);
      check("reset.out", bus.out, 32'h0);
      check("reset.busy", bus.busy, 1'b0);
      check("reset.done", bus.done, 1'b0);
      check("reset.zero", bus.zero, FLAGS_EN);
      check("reset.overflow", bus.overflow, 1'b0);
      check("reset.negative", bus.negative, 1'b0);
      reset = 1'b1;
      @(negedge clock);

      run_op("add", 32'd7, 32'hFFFF_FFFD, 3'd2, 1'b0);
      run_op("sub", 32'd5, 32'd7, 3'd3, 1'b0);
      run_op("add_ovf", 32'h7FFF_FFFF, 32'd1, 3'd2, 1'b0);
      run_op("uadd", 32'hFFFF_FFFF, 32'd1, 3'd0, 1'b0);
      run_op("code1", 32'h8000_0000, 32'd1, 3'd1, 1'b0);
      run_op("and", 32'hF0F0_F0F0, 32'hFF00_FF00, 3'd4, 1'b0);
      run_op("or", 32'hF0F0_F0F0, 32'hFF00_FF00, 3'd5, 1'b0);
      run_op("nor", 32'hF0F0_F0F0, 32'hFF00_FF00, 3'd6, 1'b0);
      run_op("xor", 32'hF0F0_F0F0, 32'hFF00_FF00, 3'd7, 1'b0);
      run_op("sub_ovf", 32'h8000_0000, 32'd1, 3'd3, 1'b0);
      run_op("inject", 32'h1234_5678, 32'h0FED_CBA9, 3'd3, 1'b1);
      run_op("back2back", 32'h0000_0100, 32'h0000_0023, 3'd2, 1'b0);

      for (int i = 0; i < 30; i++) begin
         ra = $urandom;
         rb = $urandom;
         rc = 3'($urandom_range(0, 7));
         if (i % 7 == 3) begin
            rb = ra;
         end
         run_op("rand", ra, rb, rc, (i % 5 == 0));
      end

      // Abort a SUB after bit 17 has been processed.
      bus.A       = 32'h0BAD_F00D;
      bus.B       = 32'h0000_1234;
      bus.control = 3'd3;
      bus.start   = 1'b1;
      @(posedge clock);
      @(negedge clock);
      bus.start = 1'b0;
      repeat (17) @(negedge clock);
      check("abort.busy_pre", bus.busy, 1'b1);
      reset = 1'b0;
      #1;
      check("abort.out", bus.out, 32'h0);
      check("abort.busy", bus.busy, 1'b0);
      check("abort.done", bus.done, 1'b0);
      check("abort.zero", bus.zero, FLAGS_EN);
      @(negedge clock);
      reset = 1'b1;
      prev_out = '0;
      @(negedge clock);
      run_op("after_abort", 32'd2, 32'd2, 3'd2, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end
endmodule
